// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: load-use bubbles, redirect flushes and dmem-wait freeze with timeout.
// Optional performance counters are compiled in when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
`ifdef HAZ_PERF_CNT_EN
  , parameter int unsigned PERF_W    = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead_ex,
  input  logic [4:0]        rdAddr_ex,
  input  logic [4:0]        rs1Addr_id,
  input  logic [4:0]        rs2Addr_id,
  input  logic              rs1Used_id,
  input  logic              rs2Used_id,
  input  logic              Redirect_ex,
  input  logic              dmem_req_mem,
  input  logic              dmem_ready,
  output logic              PC_stall,
  output logic              IFID_stall,
  output logic              IFID_flush,
  output logic              IDEX_stall,
  output logic              IDEX_flush,
  output logic              EXMEM_stall,
  output logic              MEMWB_bubble,
  output logic              mem_err
`ifdef HAZ_PERF_CNT_EN
  , output logic [PERF_W-1:0] stall_cycles
  , output logic [PERF_W-1:0] flush_events
`endif
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;

  logic mem_busy;
  logic load_use;
  logic freeze;
  logic redirect_flush;

  assign mem_busy = dmem_req_mem & ~dmem_ready;

  assign load_use = MemRead_ex & (rdAddr_ex != 5'd0) &
                    ((rs1Used_id & (rs1Addr_id == rdAddr_ex)) |
                     (rs2Used_id & (rs2Addr_id == rdAddr_ex)));

  // ERR freezes unconditionally; RUN and WAIT freeze only while the access is still pending.
  assign freeze = (state_q == S_ERR) | mem_busy;

  assign redirect_flush = rst_n & ~freeze & Redirect_ex;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    unique case (state_q)
      S_RUN: begin
        if (mem_busy) begin
          state_d    = S_WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (!mem_busy) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TIMEOUT_C) begin
          state_d   = S_ERR;
          mem_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Zero-latency controls; reset fills the pipe with NOPs, then freeze > redirect > load-use.
  always_comb begin
    PC_stall     = 1'b0;
    IFID_stall   = 1'b0;
    IFID_flush   = 1'b0;
    IDEX_stall   = 1'b0;
    IDEX_flush   = 1'b0;
    EXMEM_stall  = 1'b0;
    MEMWB_bubble = 1'b0;
    if (!rst_n) begin
      IFID_flush   = 1'b1;
      IDEX_flush   = 1'b1;
      MEMWB_bubble = 1'b1;
    end else if (freeze) begin
      PC_stall     = 1'b1;
      IFID_stall   = 1'b1;
      IDEX_stall   = 1'b1;
      EXMEM_stall  = 1'b1;
      MEMWB_bubble = 1'b1;
    end else if (Redirect_ex) begin
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
    end else if (load_use) begin
      PC_stall   = 1'b1;
      IFID_stall = 1'b1;
      IDEX_flush = 1'b1;
    end
  end

  assign mem_err = mem_err_q;

`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [PERF_W-1:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (PC_stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + PERF_W'(1);
    if (redirect_flush && (flush_events_q != '1)) flush_events_d = flush_events_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`else
  logic unused_redirect_flush;
  assign unused_redirect_flush = redirect_flush;
`endif

endmodule
